// File: rtl/spi_flash_cmd_sched.sv
// Two-requester SPI flash command scheduler: round-robin grant, then one mode-0
// transaction per grant (CS setup, TX bytes, read bytes, CS hold, inter-command gap).
module spi_flash_cmd_sched #(
    parameter int unsigned DIV     = 2,
    parameter int unsigned CS_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_tx,
    input  logic [2:0]  a_tx_len,
    input  logic [2:0]  a_rd_len,
    output logic        a_resp_vld,
    output logic [31:0] a_resp,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_tx,
    input  logic [2:0]  b_tx_len,
    input  logic [2:0]  b_rd_len,
    output logic        b_resp_vld,
    output logic [31:0] b_resp,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned DIV_W = $clog2(DIV + 1);
    localparam int unsigned GAP_W = $clog2(CS_IDLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_DONE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    state_t            state, state_nxt;
    logic              owner, owner_nxt;           // 0 = A, 1 = B
    logic              last_grant, last_grant_nxt;
    logic              is_null, is_null_nxt;
    logic [31:0]       tx_sh, tx_sh_nxt;
    logic [31:0]       rx, rx_nxt;
    logic [5:0]        nbits_m1, nbits_m1_nxt;
    logic [5:0]        txbits, txbits_nxt;
    logic [5:0]        bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;

    logic              a_ready_nxt, b_ready_nxt, a_resp_vld_nxt, b_resp_vld_nxt;
    logic [31:0]       a_resp_nxt, b_resp_nxt;
    logic              busy_nxt, cs_n_nxt, sck_nxt, mosi_nxt;

    logic              pick_a, pick_b;
    logic [31:0]       sel_tx;
    logic [2:0]        sel_txl, sel_rdl;
    logic [3:0]        sel_bytes;
    logic [6:0]        sel_nbits;

    function automatic logic [2:0] clamp4(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

    // Keep only the TX bytes actually sent so read-phase MOSI shifts out zeros.
    function automatic logic [31:0] tx_mask(input logic [2:0] n);
        case (n)
            3'd1:    return 32'hFF00_0000;
            3'd2:    return 32'hFFFF_0000;
            3'd3:    return 32'hFFFF_FF00;
            3'd4:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            is_null    <= 1'b0;
            tx_sh      <= '0;
            rx         <= '0;
            nbits_m1   <= '0;
            txbits     <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            a_ready    <= 1'b0;
            b_ready    <= 1'b0;
            a_resp_vld <= 1'b0;
            b_resp_vld <= 1'b0;
            a_resp     <= '0;
            b_resp     <= '0;
            busy       <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            is_null    <= is_null_nxt;
            tx_sh      <= tx_sh_nxt;
            rx         <= rx_nxt;
            nbits_m1   <= nbits_m1_nxt;
            txbits     <= txbits_nxt;
            bit_cnt    <= bit_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            a_ready    <= a_ready_nxt;
            b_ready    <= b_ready_nxt;
            a_resp_vld <= a_resp_vld_nxt;
            b_resp_vld <= b_resp_vld_nxt;
            a_resp     <= a_resp_nxt;
            b_resp     <= b_resp_nxt;
            busy       <= busy_nxt;
            spi_cs_n   <= cs_n_nxt;
            spi_clk    <= sck_nxt;
            spi_mosi   <= mosi_nxt;
        end
    end

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        pick_a    = a_valid && (!b_valid || last_grant);
        pick_b    = b_valid && !pick_a;
        sel_tx    = pick_b ? b_tx : a_tx;
        sel_txl   = clamp4(pick_b ? b_tx_len : a_tx_len);
        sel_rdl   = clamp4(pick_b ? b_rd_len : a_rd_len);
        sel_bytes = 4'(sel_txl) + 4'(sel_rdl);
        sel_nbits = {sel_bytes, 3'b000} - 7'd1;
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        is_null_nxt    = is_null;
        tx_sh_nxt      = tx_sh;
        rx_nxt         = rx;
        nbits_m1_nxt   = nbits_m1;
        txbits_nxt     = txbits;
        bit_cnt_nxt    = bit_cnt;
        div_cnt_nxt    = div_cnt;
        gap_cnt_nxt    = gap_cnt;
        a_ready_nxt    = 1'b0;
        b_ready_nxt    = 1'b0;
        a_resp_vld_nxt = 1'b0;
        b_resp_vld_nxt = 1'b0;
        a_resp_nxt     = a_resp;
        b_resp_nxt     = b_resp;
        busy_nxt       = busy;
        cs_n_nxt       = spi_cs_n;
        sck_nxt        = spi_clk;
        mosi_nxt       = spi_mosi;

        case (state)
            S_IDLE: begin
                if (pick_a || pick_b) begin
                    owner_nxt      = pick_b;
                    last_grant_nxt = pick_b;
                    a_ready_nxt    = pick_a;
                    b_ready_nxt    = pick_b;
                    is_null_nxt    = (sel_txl == 3'd0);
                    tx_sh_nxt      = sel_tx & tx_mask(sel_txl);
                    txbits_nxt     = {sel_txl, 3'b000};
                    nbits_m1_nxt   = sel_nbits[5:0];
                    state_nxt      = S_GRANT;
                end
            end
            S_GRANT: begin
                busy_nxt = 1'b1;
                if (is_null) begin
                    a_resp_vld_nxt = !owner;
                    b_resp_vld_nxt = owner;
                    if (owner) b_resp_nxt = '0;
                    else       a_resp_nxt = '0;
                    state_nxt = S_DONE;
                end else begin
                    cs_n_nxt    = 1'b0;
                    sck_nxt     = 1'b0;
                    mosi_nxt    = tx_sh[31];
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    rx_nxt      = '0;
                    state_nxt   = S_SETUP;
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            S_SETUP, S_SHIFT: begin
                if (div_cnt == DIV_W'(DIV - 1)) begin
                    div_cnt_nxt = '0;
                    if (state == S_SHIFT && spi_clk) begin
                        sck_nxt = 1'b0;
                        if (bit_cnt == nbits_m1) begin
                            mosi_nxt  = 1'b0;
                            state_nxt = S_HOLD;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 6'd1;
                            mosi_nxt    = tx_sh[30];
                            tx_sh_nxt   = {tx_sh[30:0], 1'b0};
                        end
                    end else begin
                        // Rising edge: capture MISO only for read-phase bits.
                        sck_nxt   = 1'b1;
                        state_nxt = S_SHIFT;
                        if (bit_cnt >= txbits) rx_nxt = {rx[30:0], spi_miso};
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (div_cnt == DIV_W'(DIV - 1)) begin
                    div_cnt_nxt    = '0;
                    cs_n_nxt       = 1'b1;
                    gap_cnt_nxt    = '0;
                    a_resp_vld_nxt = !owner;
                    b_resp_vld_nxt = owner;
                    if (owner) b_resp_nxt = rx;
                    else       a_resp_nxt = rx;
                    state_nxt = S_GAP;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(CS_IDLE - 1)) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_cmd_sched.sv
// Directed bench for spi_flash_cmd_sched (DIV=2, CS_IDLE=4) with a small flash MISO model.
module tb_spi_flash_cmd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready, a_resp_vld, b_resp_vld;
    logic [31:0] a_tx = '0, b_tx = '0;
    logic [2:0]  a_tx_len = '0, a_rd_len = '0, b_tx_len = '0, b_rd_len = '0;
    logic [31:0] a_resp, b_resp;
    logic        busy, spi_cs_n, spi_clk, spi_mosi;
    logic        spi_miso = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          sck_pulses = 0;
    int          cs_low = 0;
    int          a_cnt = 0;
    int          b_cnt = 0;
    int          falls = 0;
    int          hi_run = 0;
    int          min_gap = 1000;
    logic [63:0] mosi_sr = '0;
    logic [63:0] miso_pat = '0;
    logic [63:0] miso_sr = '0;

    spi_flash_cmd_sched dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_tx(a_tx), .a_tx_len(a_tx_len),
        .a_rd_len(a_rd_len), .a_resp_vld(a_resp_vld), .a_resp(a_resp),
        .b_valid(b_valid), .b_ready(b_ready), .b_tx(b_tx), .b_tx_len(b_tx_len),
        .b_rd_len(b_rd_len), .b_resp_vld(b_resp_vld), .b_resp(b_resp),
        .busy(busy), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!spi_cs_n) cs_low = cs_low + 1;
        if (a_resp_vld) a_cnt = a_cnt + 1;
        if (b_resp_vld) b_cnt = b_cnt + 1;
        if (spi_cs_n) hi_run = hi_run + 1;
        else if (hi_run > 0) begin
            if (hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
        end
    end

    always @(posedge spi_clk) begin
        sck_pulses = sck_pulses + 1;
        mosi_sr = {mosi_sr[62:0], spi_mosi};
    end

    // Flash model: one command byte, then read bits shifted out on each SCK fall.
    always @(negedge spi_cs_n) begin
        falls = 0;
        miso_sr = miso_pat;
        spi_miso = 1'b0;
    end

    always @(negedge spi_clk) begin
        falls = falls + 1;
        if (falls >= 8) begin
            spi_miso = miso_sr[63];
            miso_sr = {miso_sr[62:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clr_mon();
        sck_pulses = 0;
        cs_low = 0;
        mosi_sr = '0;
        a_cnt = 0;
        b_cnt = 0;
    endtask

    // Issue one descriptor, wait for grant and completion; return both cycle stamps.
    task automatic do_req(input bit is_b, input logic [31:0] tx, input logic [2:0] txl,
                          input logic [2:0] rdl, output int t_rdy, output int t_rsp);
        bit got;
        t_rdy = -1;
        t_rsp = -1;
        @(negedge clk);
        if (is_b) begin b_tx = tx; b_tx_len = txl; b_rd_len = rdl; b_valid = 1'b1; end
        else      begin a_tx = tx; a_tx_len = txl; a_rd_len = rdl; a_valid = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((is_b ? b_ready : a_ready) === 1'b1) begin
                got = 1'b1;
                t_rdy = cyc;
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
        check("grant_seen", 64'(got), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            if ((is_b ? b_resp_vld : a_resp_vld) === 1'b1) begin
                got = 1'b1;
                t_rsp = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("resp_seen", 64'(got), 64'd1);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int t_r, t_c;
        int grants;
        logic [7:0] gseq;
        bit hit;

        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(spi_cs_n), 64'd1);
        check("rst_sck", 64'(spi_clk), 64'd0);
        check("rst_outs", 64'({spi_mosi, a_ready, b_ready, a_resp_vld, b_resp_vld, busy}), 64'd0);
        check("rst_resp", {a_resp, b_resp}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A WREN: 8 pulses, opcode on MOSI, 34 cycles of CS low.
        clr_mon();
        do_req(1'b0, 32'h0600_0000, 3'd1, 3'd0, t_r, t_c);
        check("wren_pulses", 64'(sck_pulses), 64'd8);
        check("wren_mosi", mosi_sr, 64'h06);
        check("wren_cs_low", 64'(cs_low), 64'd34);
        check("wren_a_vld", 64'(a_cnt), 64'd1);
        check("wren_b_vld", 64'(b_cnt), 64'd0);
        check("wren_latency", 64'(t_c - t_r), 64'd35);
        check("wren_busy_idle", 64'(busy), 64'd0);

        // A with rd_len=6 clamps to 4 read bytes -> 40 pulses.
        clr_mon();
        miso_pat = 64'h1122_3344_5566_7788;
        do_req(1'b0, 32'h0300_0000, 3'd1, 3'd6, t_r, t_c);
        check("rd6_pulses", 64'(sck_pulses), 64'd40);
        check("rd6_resp", 64'(a_resp), 64'h1122_3344);
        check("rd6_cs_low", 64'(cs_low), 64'd162);

        // B RDSR: A's response must stay untouched.
        clr_mon();
        miso_pat = 64'hA500_0000_0000_0000;
        do_req(1'b1, 32'h0500_0000, 3'd1, 3'd1, t_r, t_c);
        check("rdsr_pulses", 64'(sck_pulses), 64'd16);
        check("rdsr_mosi", mosi_sr, 64'h0500);
        check("rdsr_b_resp", 64'(b_resp), 64'hA5);
        check("rdsr_a_resp", 64'(a_resp), 64'h1122_3344);
        check("rdsr_a_vld", 64'(a_cnt), 64'd0);

        // B RDID: three read bytes, first one most significant.
        clr_mon();
        miso_pat = 64'hEF40_1600_0000_0000;
        do_req(1'b1, 32'h9F00_0000, 3'd1, 3'd3, t_r, t_c);
        check("rdid_resp", 64'(b_resp), 64'h00EF_4016);
        check("rdid_pulses", 64'(sck_pulses), 64'd32);

        // Both valid continuously: grants alternate starting with A.
        clr_mon();
        miso_pat = 64'hA500_0000_0000_0000;
        min_gap = 1000;
        @(negedge clk);
        a_tx = 32'h0500_0000; a_tx_len = 3'd1; a_rd_len = 3'd1;
        b_tx = 32'h0500_0000; b_tx_len = 3'd1; b_rd_len = 3'd1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        grants = 0;
        gseq = '0;
        for (int i = 0; i < 3000 && grants < 4; i++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                gseq = {gseq[6:0], b_ready};
                grants = grants + 1;
            end
            if (a_ready && b_ready) grants = grants + 10;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (80) @(negedge clk);
        check("rr_grants", 64'(grants), 64'd4);
        check("rr_order", 64'(gseq[3:0]), 64'b0101);
        check("rr_gap_ge4", 64'(min_gap >= 4), 64'd1);
        check("rr_a_cnt", 64'(a_cnt), 64'd2);
        check("rr_b_cnt", 64'(b_cnt), 64'd2);
        check("rr_a_resp", 64'(a_resp), 64'hA5);

        // Null command: resp at T+1, no bus activity, resp cleared.
        clr_mon();
        do_req(1'b0, 32'hAB00_0000, 3'd0, 3'd2, t_r, t_c);
        check("null_latency", 64'(t_c - t_r), 64'd1);
        check("null_resp", 64'(a_resp), 64'd0);
        check("null_pulses", 64'(sck_pulses), 64'd0);
        check("null_cs_low", 64'(cs_low), 64'd0);

        // Reset while SCK is high in the shift phase.
        clr_mon();
        miso_pat = 64'hA500_0000_0000_0000;
        @(negedge clk);
        b_tx = 32'h0500_0000; b_tx_len = 3'd1; b_rd_len = 3'd1;
        b_valid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (b_ready) hit = 1'b1;
        end
        b_valid = 1'b0;
        check("rst_grant", 64'(hit), 64'd1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (spi_clk && sck_pulses >= 3) hit = 1'b1;
        end
        check("rst_sck_high", 64'(hit), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_cs_n", 64'(spi_cs_n), 64'd1);
        check("abort_sck", 64'(spi_clk), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_resp", 64'(b_cnt), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);

        clr_mon();
        do_req(1'b1, 32'h0500_0000, 3'd1, 3'd1, t_r, t_c);
        check("post_rst_resp", 64'(b_resp), 64'hA5);
        check("post_rst_pulses", 64'(sck_pulses), 64'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
